// File: rtl/mul_wb_stage_if.sv
// mul_wb_stage_if -- bundles the two handshakes of the multiplier write-back
// stage: the upstream result port (in_*) and the register-file port (wb_*).
//
// Handshake: a transfer happens on a rising clk edge where valid=1 and
// ready=1. A producer holding valid=1 keeps its payload stable until the
// transfer. A consumer may raise or drop ready at any time. On the stage
// side, in_ready never depends combinationally on wb_ready.
//
// Modports:
//   slave  - the write-back stage (accepts in_*, produces wb_*)
//   master - the environment (drives in_* and wb_ready)
interface mul_wb_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_result;
  logic [3:0] in_status;
  logic [2:0] in_rd;
  logic       in_we;

  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] wb_data;
  logic [2:0] wb_rd;
  logic       wb_we;

  modport slave (
    input  in_valid, in_result, in_status, in_rd, in_we, wb_ready,
    output in_ready, wb_valid, wb_data, wb_rd, wb_we
  );

  modport master (
    output in_valid, in_result, in_status, in_rd, in_we, wb_ready,
    input  in_ready, wb_valid, wb_data, wb_rd, wb_we
  );
endinterface

// File: rtl/mul_wb_stage.sv
// mul_wb_stage -- FIFO buffer between the multiplier and the register file.
// Each entry holds {result, status, rd, we}. The oldest entry is presented on
// wb_*; on every pop its status is committed into the flags register.
//
// Ports:
//   clk, rst   - clock (rising edge), asynchronous active-high reset
//   bus        - mul_wb_stage_if.slave: in_* push port, wb_* pop port
//   flush      - drop all buffered entries (and any push/pop on that edge)
//   clr_flags  - synchronous clear of flags, wins over a concurrent pop
//   flags      - committed status register
//   count      - number of occupied entries
//
// Parameter DEPTH: entry count, power of two, at least 2.
// Macro STICKY_CARRY_EN: when defined, flags[3] (carry) is sticky -- set by
// any popped entry with carry and held until clr_flags or reset.
module mul_wb_stage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  mul_wb_stage_if.slave            bus,
  input  logic                     flush,
  input  logic                     clr_flags,
  output logic [3:0]               flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [3:0]    flags_q;
  logic [3:0]    flags_nxt;
  // Held low through reset and set by the first edge after release, so that
  // in_ready stays 0 while rst is asserted.
  logic          rdy_q;

  logic          push;
  logic          pop;
  logic [15:0]   head;
  logic [3:0]    head_status;

  assign head        = mem[rd_ptr];
  assign head_status = head[7:4];

  assign bus.in_ready = rdy_q && (count_q < CW'(DEPTH));
  assign bus.wb_valid = (count_q != '0);

  // Head fields are gated by wb_valid so they read 0 while empty or in reset.
  assign bus.wb_data = bus.wb_valid ? head[15:8] : 8'h00;
  assign bus.wb_rd   = bus.wb_valid ? head[3:1]  : 3'h0;
  assign bus.wb_we   = bus.wb_valid ? head[0]    : 1'b0;

  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop  = bus.wb_valid && bus.wb_ready && !flush;

  assign flags = flags_q;
  assign count = count_q;

  // Entry storage needs no reset: it is only observed through wb_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_result, bus.in_status, bus.in_rd, bus.in_we};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_q <= '0;
      end else begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  always_comb begin
    flags_nxt = flags_q;
    if (clr_flags) begin
      flags_nxt = 4'h0;
    end else if (pop) begin
`ifdef STICKY_CARRY_EN
      flags_nxt = {flags_q[3] | head_status[3], head_status[2:0]};
`else
      flags_nxt = head_status;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'h0;
    end else begin
      flags_q <= flags_nxt;
    end
  end

endmodule

// File: tb/tb_mul_wb_stage.sv
// tb_mul_wb_stage -- directed self-checking bench for mul_wb_stage (DEPTH=4).
module tb_mul_wb_stage;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       clr_flags;
  logic [3:0] flags;
  logic [2:0] count;

  int errors;
  int checks;

  logic [7:0] exp_q[$];

  mul_wb_stage_if bus();

  mul_wb_stage #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .flush     (flush),
    .clr_flags (clr_flags),
    .flags     (flags),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_result = 8'h00;
    bus.in_status = 4'h0;
    bus.in_rd     = 3'h0;
    bus.in_we     = 1'b0;
    bus.wb_ready  = 1'b0;
    flush         = 1'b0;
    clr_flags     = 1'b0;
  endtask

  task automatic drive_in(input logic [7:0] r, input logic [3:0] s,
                          input logic [2:0] rd, input logic we);
    bus.in_valid  = 1'b1;
    bus.in_result = r;
    bus.in_status = s;
    bus.in_rd     = rd;
    bus.in_we     = we;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", flags); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.wb_data !== 8'h00) begin errors++; $display("FAIL reset_wb_data: got %h expected 00", bus.wb_data); end
    rst = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_single();
    drive_in(8'h2A, 4'h0, 3'd5, 1'b1);
    bus.wb_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.wb_valid); end
    checks++; if (bus.wb_data !== 8'h2A) begin errors++; $display("FAIL single_data: got %h expected 2a", bus.wb_data); end
    checks++; if (bus.wb_rd !== 3'd5) begin errors++; $display("FAIL single_rd: got %0d expected 5", bus.wb_rd); end
    checks++; if (bus.wb_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", bus.wb_we); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d expected 0", count); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL single_flags: got %h expected 0", flags); end
    bus.wb_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] st [4];
    st[0] = 4'h1; st[1] = 4'h2; st[2] = 4'h3; st[3] = 4'h7;
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_in(8'h10 + 8'(i), st[i], 3'(i), 1'b1);
      exp_q.push_back(8'h10 + 8'(i));
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
    // Fifth entry offered while full: refused and held upstream.
    drive_in(8'h14, 4'h0, 3'd4, 1'b1);
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_fifth_refused: got %0d expected 4", count); end
    checks++; if (bus.wb_data !== 8'h10) begin errors++; $display("FAIL fill_hold_data: got %h expected 10", bus.wb_data); end
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++; if (bus.wb_data !== e) begin errors++; $display("FAIL fill_drain_%0d: got %h expected %h", i, bus.wb_data, e); end
      step();
    end
    bus.wb_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fill_drained_count: got %0d expected 0", count); end
    checks++; if (flags !== 4'h7) begin errors++; $display("FAIL fill_flags: got %h expected 7", flags); end
  endtask

  task automatic test_back_to_back();
    int k;
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_in(8'h40 + 8'(i), 4'h0, 3'(i), 1'b0);
      exp_q.push_back(8'h40 + 8'(i));
      step();
    end
    bus.wb_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      drive_in(8'h50 + 8'(k), 4'h0, 3'(k), 1'b1);
      if (i == 0) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", bus.in_ready); end
      end else begin
        // Count is 3 on every later edge, so the offered item is accepted.
        exp_q.push_back(8'h50 + 8'(k));
        k++;
      end
      e = exp_q.pop_front();
      checks++; if (bus.wb_data !== e) begin errors++; $display("FAIL b2b_order_%0d: got %h expected %h", i, bus.wb_data, e); end
      step();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL b2b_count_%0d: got %0d expected 3", i, count); end
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      checks++; if (bus.wb_data !== e) begin errors++; $display("FAIL b2b_tail_%0d: got %h expected %h", i, bus.wb_data, e); end
      step();
    end
    bus.wb_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_end_count: got %0d expected 0", count); end
  endtask

  task automatic test_flags();
    bus.wb_ready = 1'b0;
    drive_in(8'h31, 4'h8, 3'd1, 1'b0);
    step();
    drive_in(8'h32, 4'h4, 3'd2, 1'b1);
    step();
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    step();
    checks++; if (flags !== 4'h8) begin errors++; $display("FAIL flags_first: got %h expected 8", flags); end
    step();
`ifdef STICKY_CARRY_EN
    checks++; if (flags !== 4'hC) begin errors++; $display("FAIL flags_second: got %h expected c", flags); end
`else
    checks++; if (flags !== 4'h4) begin errors++; $display("FAIL flags_second: got %h expected 4", flags); end
`endif
    bus.wb_ready = 1'b0;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL flags_clear: got %h expected 0", flags); end
    // Clear and pop on the same edge: the clear wins.
    drive_in(8'h33, 4'hF, 3'd3, 1'b1);
    step();
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b1;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    bus.wb_ready = 1'b0;
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL flags_clr_wins: got %h expected 0", flags); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flags_clr_pop_count: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    drive_in(8'h35, 4'h5, 3'd1, 1'b1);
    bus.wb_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    checks++; if (flags !== 4'h5) begin errors++; $display("FAIL flush_preset_flags: got %h expected 5", flags); end
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_in(8'h60 + 8'(i), 4'hA, 3'(i), 1'b1);
      step();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    drive_in(8'h70, 4'hF, 3'd7, 1'b1);
    bus.wb_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.wb_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (flags !== 4'h5) begin errors++; $display("FAIL flush_flags: got %h expected 5", flags); end
  endtask

  task automatic test_reset_mid();
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_in(8'h80 + 8'(i), 4'h3, 3'(i), 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 2", count); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL rstmid_flags: got %h expected 0", flags); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 0", bus.in_ready); end
    #1;
    rst = 1'b0;
    step();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready: got %b expected 1", bus.in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_release_count: got %0d expected 0", count); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flags();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_wb_stage.md
MUL_WB_STAGE -- requirements
Module: mul_wb_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter DEPTH, default 4, SHALL set the buffer entry count and SHALL be a power of two, minimum 2.
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream multiplier result present.
- in_ready  out  1  stage can accept an entry.
- in_result  in  8  low product byte.
- in_status  in  4  status flags: [3]=carry, [2]=zero, [1:0]=reserved pass-through.
- in_rd  in  3  destination register index.
- in_we  in  1  register write enable for this entry.
- flush  in  1  discard all buffered entries.
- wb_valid  out  1  head entry present.
- wb_ready  in  1  register file accepts the head.
- wb_data  out  8  head result.
- wb_rd  out  3  head destination index.
- wb_we  out  1  head write enable.
- flags  out  4  committed status register.
- clr_flags  in  1  synchronous clear of flags.
- count  out  log2(DEPTH)+1  occupied entries.

Function
REQ-004 Entries SHALL be buffered first-in first-out, each holding {in_result, in_status, in_rd, in_we}.
REQ-005 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1 and flush=0.
REQ-006 A pop SHALL occur on a rising edge where wb_valid=1 and wb_ready=1 and flush=0.
REQ-007 in_ready SHALL be 1 exactly when count < DEPTH; in_ready SHALL NOT depend combinationally on wb_ready.
REQ-008 wb_valid SHALL be 1 exactly when count > 0; wb_data, wb_rd and wb_we SHALL show the oldest entry.
REQ-009 Latency SHALL be one cycle: an entry pushed into an empty buffer at edge N SHALL be visible on the wb_ outputs after edge N.
REQ-010 A simultaneous push and pop SHALL leave count unchanged and SHALL preserve order.
REQ-011 When full, an edge with in_valid=1 and wb_ready=1 SHALL pop only; the push is refused because in_ready=0.
REQ-012 Read and write pointers SHALL wrap modulo DEPTH with no loss of entries.
REQ-013 Holding rule: while wb_valid=1 and wb_ready=0, the wb_ outputs SHALL stay stable.
REQ-014 flush=1 at an edge SHALL set count to 0 and SHALL drop any concurrent push and pop; flags SHALL be unaffected.
REQ-015 On each pop, flags SHALL load the popped entry's status, whether its wb_we is 0 or 1.
REQ-016 clr_flags=1 at an edge SHALL set flags to 0; if a pop occurs on the same edge, clr_flags SHALL win.
REQ-017 The block SHALL perform no arithmetic on the data; wb_data SHALL equal in_result bit-for-bit.

Reset
REQ-018 While rst=1, the block SHALL asynchronously force count=0, wb_valid=0, flags=0, the pointers to 0, and wb_data, wb_rd and wb_we to 0.
REQ-019 While rst=1, in_ready SHALL be 0; it SHALL go to 1 at the first edge after rst deasserts.
REQ-020 Reset asserted mid-operation SHALL discard all entries without any pop or flag update.

Configuration
REQ-021 Macro STICKY_CARRY_EN SHALL select the carry behaviour of flags[3]:
- Defined: flags[3] becomes 1 on any pop whose status[3]=1 and holds 1 until clr_flags or reset; bits [2:0] follow REQ-015.
- Undefined: all four flag bits follow REQ-015.

Verification
REQ-022 Push result=0x2A, status=0x0, rd=5, we=1 into an empty buffer, wb_ready=1 -> the next cycle shows wb_valid=1, wb_data=0x2A, wb_rd=5; after the pop, flags=0x0.
REQ-023 With wb_ready=0, push 5 entries with DEPTH=4 -> count=4, in_ready=0 after the fourth push, the fifth entry is held upstream; set wb_ready=1 -> entries drain in push order.
REQ-024 With the buffer full, assert in_valid=1 and wb_ready=1 for 8 cycles -> count stays between 3 and 4, output order is correct, and the pointers wrap twice.
REQ-025 Pop status=0x8, then status=0x4:
- With STICKY_CARRY_EN -> flags=0x8, then 0xC.
- Without it -> flags=0x8, then 0x4.
- With STICKY_CARRY_EN, clr_flags -> flags=0x0.
REQ-026 With 3 entries buffered, assert flush together with in_valid and wb_ready -> count=0, wb_valid=0, flags unchanged.
REQ-027 With 2 entries buffered, assert rst asynchronously mid-cycle -> count=0, wb_valid=0, flags=0 immediately; after release, in_ready=1 at the next edge.
